// File: rtl/spi_tx.sv
// ============================================================================
// Module   : spi_tx
// Purpose  : Transmit-only SPI master (mode 0), MSB first, active-low select.
//            Optional done_out pulse when built with SPI_TX_DONE_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_PERIOD = 100
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  trigger_in,
    output logic                  data_out,
    output logic                  data_clk_out,
    output logic                  sel_out
`ifdef SPI_TX_DONE_EN
    ,
    output logic                  done_out
`endif
);

    localparam int PC_W = $clog2(DATA_PERIOD);
    localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(DATA_PERIOD - 1);
    localparam logic [PC_W-1:0] PC_HALF  = PC_W'(DATA_PERIOD / 2);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("spi_tx: DATA_WIDTH must be >= 1");
        end
        if (DATA_PERIOD < 2) begin : g_bad_period
            $error("spi_tx: DATA_PERIOD must be >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BC_W-1:0]       bit_cnt;
    logic [PC_W-1:0]       pc;

    logic [DATA_WIDTH-1:0] shifted;
    logic [PC_W-1:0]       pc_inc;
    logic                  pc_wrap;
    logic                  last_bit;

    // A plain shift works for every width, including a single-bit word.
    assign shifted  = shift_reg << 1;
    assign pc_inc   = pc + 1'b1;
    assign pc_wrap  = (pc == PC_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            pc           <= '0;
            data_out     <= 1'b0;
            data_clk_out <= 1'b0;
            sel_out      <= 1'b1;
`ifdef SPI_TX_DONE_EN
            done_out     <= 1'b0;
`endif
        end else begin
`ifdef SPI_TX_DONE_EN
            done_out <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (trigger_in) begin
                        state        <= TRANSMIT;
                        shift_reg    <= data_in;
                        bit_cnt      <= '0;
                        pc           <= '0;
                        data_out     <= data_in[DATA_WIDTH-1];
                        data_clk_out <= 1'b0;
                        sel_out      <= 1'b0;
                    end
                end

                TRANSMIT: begin
                    if (pc_wrap) begin
                        if (last_bit) begin
                            // All outputs drop to idle together: no trailing clock edge.
                            state        <= IDLE;
                            shift_reg    <= '0;
                            bit_cnt      <= '0;
                            pc           <= '0;
                            data_out     <= 1'b0;
                            data_clk_out <= 1'b0;
                            sel_out      <= 1'b1;
`ifdef SPI_TX_DONE_EN
                            done_out     <= 1'b1;
`endif
                        end else begin
                            shift_reg    <= shifted;
                            data_out     <= shifted[DATA_WIDTH-1];
                            bit_cnt      <= bit_cnt + 1'b1;
                            pc           <= '0;
                            data_clk_out <= 1'b0;
                        end
                    end else begin
                        pc           <= pc_inc;
                        data_clk_out <= (pc_inc >= PC_HALF);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_tx.sv
// ============================================================================
// Module   : tb_spi_tx
// Purpose  : Directed self-checking bench for spi_tx (W=16/P=10 and W=1/P=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_tx;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] data_in;
    logic        trigger_in;
    logic        data_out, data_clk_out, sel_out;

    logic        s_data_in, s_trigger_in;
    logic        s_data_out, s_data_clk_out, s_sel_out;
`ifdef SPI_TX_DONE_EN
    logic        done_out, s_done_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    spi_tx #(.DATA_WIDTH(16), .DATA_PERIOD(10)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_in      (data_in),
        .trigger_in   (trigger_in),
        .data_out     (data_out),
        .data_clk_out (data_clk_out),
        .sel_out      (sel_out)
`ifdef SPI_TX_DONE_EN
        ,
        .done_out     (done_out)
`endif
    );

    spi_tx #(.DATA_WIDTH(1), .DATA_PERIOD(2)) dut_small (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_in      (s_data_in),
        .trigger_in   (s_trigger_in),
        .data_out     (s_data_out),
        .data_clk_out (s_data_clk_out),
        .sel_out      (s_sel_out)
`ifdef SPI_TX_DONE_EN
        ,
        .done_out     (s_done_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One-cycle trigger of `word`, then watch the whole transfer. inj_at / rst_at
    // are sample indices (from the first select-low sample) for a mid-transfer
    // trigger+data change or a reset pulse; -1 disables them.
    task automatic run_xfer(input logic [15:0] word, input int inj_at,
                            input int rst_at, input string tag);
        int          low_cnt, rises, run, hi_min, hi_max, lo_min, lo_max;
        logic        prev, aborted;
        logic [15:0] cap;
        @(negedge clk_in);
        data_in    = word;
        trigger_in = 1'b1;
        @(negedge clk_in);
        trigger_in = 1'b0;
        check({tag, "_sel_start"},  32'(sel_out),      32'd0);
        check({tag, "_msb_start"},  32'(data_out),     32'(word[15]));
        check({tag, "_dclk_start"}, 32'(data_clk_out), 32'd0);
        low_cnt = 0; rises = 0; run = 0; prev = 1'b0; aborted = 1'b0; cap = '0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
        while (sel_out == 1'b0 && low_cnt < 400 && !aborted) begin
            low_cnt++;
            if (data_clk_out != prev) begin
                if (prev) begin
                    hi_min = (run < hi_min) ? run : hi_min;
                    hi_max = (run > hi_max) ? run : hi_max;
                end else begin
                    lo_min = (run < lo_min) ? run : lo_min;
                    lo_max = (run > lo_max) ? run : lo_max;
                end
                run = 1;
                if (data_clk_out) begin
                    rises++;
                    cap = {cap[14:0], data_out};
                end
            end else begin
                run++;
            end
            prev = data_clk_out;
            trigger_in = 1'b0;
            if (low_cnt - 1 == inj_at) begin
                trigger_in = 1'b1;
                data_in    = ~word;
            end
            if (low_cnt - 1 == rst_at) begin
                rst_in = 1'b1;
                #1;
                check({tag, "_rst_sel"},  32'(sel_out),      32'd1);
                check({tag, "_rst_dclk"}, 32'(data_clk_out), 32'd0);
                check({tag, "_rst_data"}, 32'(data_out),     32'd0);
                aborted = 1'b1;
            end
            if (!aborted) @(negedge clk_in);
        end
        if (aborted) begin
            @(negedge clk_in);
            rst_in = 1'b0;
        end else begin
            if (prev) begin
                hi_min = (run < hi_min) ? run : hi_min;
                hi_max = (run > hi_max) ? run : hi_max;
            end
            check({tag, "_sel_low_cycles"}, 32'(low_cnt), 32'd160);
            check({tag, "_rises"},          32'(rises),   32'd16);
            check({tag, "_bits"},           32'(cap),     32'(word));
            check({tag, "_hi_min"},         32'(hi_min),  32'd5);
            check({tag, "_hi_max"},         32'(hi_max),  32'd5);
            check({tag, "_lo_min"},         32'(lo_min),  32'd5);
            check({tag, "_lo_max"},         32'(lo_max),  32'd5);
            check({tag, "_idle_sel"},       32'(sel_out),      32'd1);
            check({tag, "_idle_dclk"},      32'(data_clk_out), 32'd0);
            check({tag, "_idle_data"},      32'(data_out),     32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen_low;
        rst_in       = 1'b1;
        data_in      = '0;
        trigger_in   = 1'b0;
        s_data_in    = 1'b0;
        s_trigger_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_sel",    32'(sel_out),      32'd1);
        check("reset_dclk",   32'(data_clk_out), 32'd0);
        check("reset_data",   32'(data_out),     32'd0);
        check("reset_s_sel",  32'(s_sel_out),    32'd1);
`ifdef SPI_TX_DONE_EN
        check("reset_done",   32'(done_out),     32'd0);
`endif
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("no_trig_idle", 32'(sel_out), 32'd1);

        run_xfer(16'hBEEF, -1, -1, "beef");
        run_xfer(16'hFEED, -1, -1, "feed");
        run_xfer(16'hA5C3, 55, -1, "midtrig");

        seen_low = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            if (sel_out == 1'b0) seen_low = 1'b1;
        end
        check("no_second_xfer", 32'(seen_low), 32'd0);

        run_xfer(16'h3C96, -1, 85, "rst_abort");
        run_xfer(16'h1234, -1, -1, "after_rst");

        // Trigger held high: three back-to-back transfers with 1-cycle gaps.
        @(negedge clk_in);
        data_in    = 16'h5A5A;
        trigger_in = 1'b1;
        @(negedge clk_in);
        for (int t = 0; t < 3; t++) begin
            if (t == 2) trigger_in = 1'b0;
            n = 0;
            while (sel_out == 1'b0 && n < 400) begin
                n++;
                @(negedge clk_in);
            end
            check($sformatf("b2b_low%0d", t), 32'(n), 32'd160);
            if (t < 2) begin
                n = 0;
                while (sel_out == 1'b1 && n < 10) begin
                    n++;
                    @(negedge clk_in);
                end
                check($sformatf("b2b_gap%0d", t), 32'(n), 32'd1);
            end
        end
        repeat (3) @(negedge clk_in);
        check("b2b_end_idle", 32'(sel_out), 32'd1);

        // W=1, P=2 instance.
        s_data_in    = 1'b1;
        s_trigger_in = 1'b1;
        @(negedge clk_in);
        s_trigger_in = 1'b0;
        check("small_c0_sel",  32'(s_sel_out),      32'd0);
        check("small_c0_dclk", 32'(s_data_clk_out), 32'd0);
        check("small_c0_data", 32'(s_data_out),     32'd1);
`ifdef SPI_TX_DONE_EN
        check("small_c0_done", 32'(s_done_out),     32'd0);
`endif
        @(negedge clk_in);
        check("small_c1_sel",  32'(s_sel_out),      32'd0);
        check("small_c1_dclk", 32'(s_data_clk_out), 32'd1);
        check("small_c1_data", 32'(s_data_out),     32'd1);
        @(negedge clk_in);
        check("small_c2_sel",  32'(s_sel_out),      32'd1);
        check("small_c2_dclk", 32'(s_data_clk_out), 32'd0);
        check("small_c2_data", 32'(s_data_out),     32'd0);
`ifdef SPI_TX_DONE_EN
        check("small_c2_done", 32'(s_done_out),     32'd1);
        check("big_done_idle", 32'(done_out),       32'd0);
`endif
        @(negedge clk_in);
        check("small_c3_sel",  32'(s_sel_out),      32'd1);
`ifdef SPI_TX_DONE_EN
        check("small_c3_done", 32'(s_done_out),     32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
